// File: rtl/mt_regfile_pkg.sv
// Shared types and constants for the multi-thread register file and its
// init sequencer.
package mt_regfile_pkg;

  localparam int DEF_NUM_TRD = 8;
  localparam int DEF_NUM_REG = 32;
  localparam int DEF_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } init_state_e;

  localparam int REG_ZERO = 0;
  localparam int REG_TID  = 1;
  localparam int REG_SP   = 2;
  localparam int REG_FP   = 3;
  localparam int REG_ARG  = 4;

  // Stacks grow down from the base; each thread sits one stride below the last.
  function automatic logic [31:0] init_sp(input logic [31:0] tid,
                                          input logic [31:0] base,
                                          input logic [31:0] stride);
    return base - tid * stride;
  endfunction

endpackage

// File: rtl/mt_regfile_init_seq.sv
// Init sequencer: reloads one thread's bank (r2..rN-1) to its start-of-thread
// state, one register per cycle, while the other threads keep running.
module mt_regfile_init_seq
  import mt_regfile_pkg::*;
#(
  parameter int          NUM_TRD        = DEF_NUM_TRD,
  parameter int          NUM_REG        = DEF_NUM_REG,
  parameter int          DATA_W         = DEF_DATA_W,
  parameter logic [31:0] INIT_SP_BASE   = 32'h0000_FFF0,
  parameter logic [31:0] INIT_SP_STRIDE = 32'h0000_1000,
  localparam int         TID_W          = $clog2(NUM_TRD),
  localparam int         REG_W          = $clog2(NUM_REG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req_i,
  input  logic [TID_W-1:0]  init_trd_i,
  input  logic [DATA_W-1:0] init_data_i,
  output logic              init_busy_o,
  output logic              init_done_o,
  output logic [TID_W-1:0]  trd_o,
  output logic              we_o,
  output logic [REG_W-1:0]  idx_o,
  output logic [DATA_W-1:0] wdata_o
);

  init_state_e       state_q;
  logic [REG_W-1:0]  idx_q;
  logic [TID_W-1:0]  trd_q;
  logic [DATA_W-1:0] init_data_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] wdata_d;

  // busy stays high through the done-pulse cycle so the next accept lands
  // exactly NUM_REG cycles after the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      trd_q       <= '0;
      init_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= init_req_i;
          if (init_req_i) begin
            state_q     <= LOAD;
            trd_q       <= init_trd_i;
            init_data_q <= init_data_i;
            idx_q       <= REG_W'(REG_SP);
          end
        end
        LOAD: begin
          idx_q <= idx_q + REG_W'(1);
          if (idx_q == REG_W'(NUM_REG - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wdata_d = '0;
    if (idx_q == REG_W'(REG_SP) || idx_q == REG_W'(REG_FP)) begin
      wdata_d = DATA_W'(init_sp(32'(trd_q), INIT_SP_BASE, INIT_SP_STRIDE));
    end else if (idx_q == REG_W'(REG_ARG)) begin
      wdata_d = init_data_q;
    end
  end

  assign init_busy_o = busy_q;
  assign init_done_o = done_q;
  assign trd_o       = trd_q;
  assign we_o        = (state_q == LOAD);
  assign idx_o       = idx_q;
  assign wdata_o     = wdata_d;

endmodule

// File: rtl/mt_regfile.sv
// Shared multi-thread register file: NUM_TRD banks, two registered read ports
// with write-through bypass, one write port and a per-thread init sequencer.
module mt_regfile
  import mt_regfile_pkg::*;
#(
  parameter int          NUM_TRD        = DEF_NUM_TRD,
  parameter int          NUM_REG        = DEF_NUM_REG,
  parameter int          DATA_W         = DEF_DATA_W,
  parameter logic [31:0] INIT_SP_BASE   = 32'h0000_FFF0,
  parameter logic [31:0] INIT_SP_STRIDE = 32'h0000_1000,
  localparam int         TID_W          = $clog2(NUM_TRD),
  localparam int         REG_W          = $clog2(NUM_REG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TID_W-1:0]  rd_trd_a,
  input  logic [TID_W-1:0]  rd_trd_b,
  input  logic [REG_W-1:0]  rd_reg_a,
  input  logic [REG_W-1:0]  rd_reg_b,
  input  logic              wr_en,
  input  logic [TID_W-1:0]  wr_trd,
  input  logic [REG_W-1:0]  wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              init_req,
  input  logic [TID_W-1:0]  init_trd,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_busy,
  output logic              init_done,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b
);

  logic [DATA_W-1:0] bank_q [NUM_TRD][NUM_REG];
  logic [DATA_W-1:0] data_a_q, data_b_q;
  logic [DATA_W-1:0] data_a_d, data_b_d;

  logic [TID_W-1:0]  seq_trd;
  logic              seq_we;
  logic [REG_W-1:0]  seq_idx;
  logic [DATA_W-1:0] seq_wdata;
  logic              wr_ok;

  mt_regfile_init_seq #(
    .NUM_TRD        (NUM_TRD),
    .NUM_REG        (NUM_REG),
    .DATA_W         (DATA_W),
    .INIT_SP_BASE   (INIT_SP_BASE),
    .INIT_SP_STRIDE (INIT_SP_STRIDE)
  ) u_init_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_req_i  (init_req),
    .init_trd_i  (init_trd),
    .init_data_i (init_data),
    .init_busy_o (init_busy),
    .init_done_o (init_done),
    .trd_o       (seq_trd),
    .we_o        (seq_we),
    .idx_o       (seq_idx),
    .wdata_o     (seq_wdata)
  );

  // Writes to the hardwired registers, or to the thread being reloaded, are dropped.
  assign wr_ok = wr_en && (wr_reg > REG_W'(REG_TID)) &&
                 !(init_busy && (wr_trd == seq_trd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TRD; t++) begin
        for (int r = 0; r < NUM_REG; r++) begin
          bank_q[t][r] <= '0;
        end
      end
    end else begin
      if (wr_ok) begin
        bank_q[wr_trd][wr_reg] <= wr_data;
      end
      if (seq_we) begin
        bank_q[seq_trd][seq_idx] <= seq_wdata;
      end
    end
  end

  // Read value with bypass: init write beats normal write beats storage.
  function automatic logic [DATA_W-1:0] rd_sel(input logic [TID_W-1:0] t,
                                               input logic [REG_W-1:0] r);
    logic [DATA_W-1:0] v;
    v = bank_q[t][r];
    if (wr_ok && (wr_trd == t) && (wr_reg == r)) begin
      v = wr_data;
    end
    if (seq_we && (seq_trd == t) && (seq_idx == r)) begin
      v = seq_wdata;
    end
    if (r == REG_W'(REG_ZERO)) begin
      v = '0;
    end else if (r == REG_W'(REG_TID)) begin
      v = DATA_W'(t);
    end
    return v;
  endfunction

  always_comb begin
    data_a_d = rd_sel(rd_trd_a, rd_reg_a);
    data_b_d = rd_sel(rd_trd_b, rd_reg_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;

endmodule

// File: tb/tb_mt_regfile.sv
// Directed bench for mt_regfile: hardwired regs, bypass, init sequencing,
// back-to-back init and asynchronous reset mid-sequence.
module tb_mt_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  rd_trd_a = '0, rd_trd_b = '0;
  logic [4:0]  rd_reg_a = '0, rd_reg_b = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_trd = '0;
  logic [4:0]  wr_reg = '0;
  logic [31:0] wr_data = '0;
  logic        init_req = 1'b0;
  logic [2:0]  init_trd = '0;
  logic [31:0] init_data = '0;
  logic        init_busy, init_done;
  logic [31:0] data_a, data_b;

  int checks = 0;
  int failures = 0;

  mt_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_trd_a  (rd_trd_a),
    .rd_trd_b  (rd_trd_b),
    .rd_reg_a  (rd_reg_a),
    .rd_reg_b  (rd_reg_b),
    .wr_en     (wr_en),
    .wr_trd    (wr_trd),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .init_req  (init_req),
    .init_trd  (init_trd),
    .init_data (init_data),
    .init_busy (init_busy),
    .init_done (init_done),
    .data_a    (data_a),
    .data_b    (data_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [2:0] ta, input logic [4:0] ra,
                        input logic [2:0] tb, input logic [4:0] rb);
    rd_trd_a = ta; rd_reg_a = ra; rd_trd_b = tb; rd_reg_b = rb;
  endtask

  task automatic do_write(input logic [2:0] t, input logic [4:0] r, input logic [31:0] d);
    wr_en = 1'b1; wr_trd = t; wr_reg = r; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL reset_data_a got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'h0) begin failures++; $display("FAIL reset_data_b got=%h exp=%h", data_b, 32'h0); end
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", init_busy); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", init_done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hardwired();
    set_rd(3'd5, 5'd0, 3'd5, 5'd1);
    tick();
    checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL t5_r0 got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'h5) begin failures++; $display("FAIL t5_r1 got=%h exp=%h", data_b, 32'h5); end
    set_rd(3'd0, 5'd7, 3'd5, 5'd1);
    tick();
    checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL t0_r7 got=%h exp=%h", data_a, 32'h0); end
    do_write(3'd5, 5'd1, 32'hDEAD);
    checks++; if (data_b !== 32'h5) begin failures++; $display("FAIL r1_write_bypass got=%h exp=%h", data_b, 32'h5); end
    tick();
    checks++; if (data_b !== 32'h5) begin failures++; $display("FAIL r1_write_stored got=%h exp=%h", data_b, 32'h5); end
  endtask

  task automatic test_bypass();
    set_rd(3'd3, 5'd9, 3'd3, 5'd9);
    do_write(3'd3, 5'd9, 32'h1234_5678);
    checks++; if (data_a !== 32'h1234_5678) begin failures++; $display("FAIL bypass_a got=%h exp=%h", data_a, 32'h1234_5678); end
    checks++; if (data_b !== 32'h1234_5678) begin failures++; $display("FAIL bypass_b got=%h exp=%h", data_b, 32'h1234_5678); end
    set_rd(3'd2, 5'd9, 3'd3, 5'd9);
    tick();
    checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL t2_r9 got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'h1234_5678) begin failures++; $display("FAIL t3_r9_stored got=%h exp=%h", data_b, 32'h1234_5678); end
  endtask

  task automatic test_init();
    int busy_cnt, done_cnt, done_at;
    do_write(3'd6, 5'd4, 32'h1111);
    do_write(3'd6, 5'd20, 32'h2222);
    init_req = 1'b1; init_trd = 3'd6; init_data = 32'hCAFE;
    tick();
    init_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k < 34; k++) begin
      if (init_busy) busy_cnt++;
      if (init_done) begin done_cnt++; done_at = k; end
      wr_en = (k == 3) || (k == 4);
      wr_trd = (k == 3) ? 3'd6 : 3'd1;
      wr_reg = 5'd10;
      wr_data = (k == 3) ? 32'd7 : 32'd9;
      init_req = (k == 6);
      init_trd = 3'd2;
      tick();
    end
    wr_en = 1'b0; init_req = 1'b0;
    checks++; if (busy_cnt !== 32) begin failures++; $display("FAIL init_busy_cycles got=%0d exp=32", busy_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL init_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_at !== 31) begin failures++; $display("FAIL init_done_cycle got=%0d exp=31", done_at); end
    set_rd(3'd6, 5'd2, 3'd6, 5'd3);
    tick();
    checks++; if (data_a !== 32'h0000_9FF0) begin failures++; $display("FAIL t6_sp got=%h exp=%h", data_a, 32'h0000_9FF0); end
    checks++; if (data_b !== 32'h0000_9FF0) begin failures++; $display("FAIL t6_fp got=%h exp=%h", data_b, 32'h0000_9FF0); end
    set_rd(3'd6, 5'd4, 3'd6, 5'd20);
    tick();
    checks++; if (data_a !== 32'hCAFE) begin failures++; $display("FAIL t6_arg got=%h exp=%h", data_a, 32'hCAFE); end
    checks++; if (data_b !== 32'h0) begin failures++; $display("FAIL t6_r20 got=%h exp=%h", data_b, 32'h0); end
    set_rd(3'd6, 5'd10, 3'd1, 5'd10);
    tick();
    checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL t6_r10_dropped got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'd9) begin failures++; $display("FAIL t1_r10 got=%h exp=%h", data_b, 32'd9); end
    set_rd(3'd2, 5'd2, 3'd6, 5'd1);
    tick();
    checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL t2_not_inited got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'h6) begin failures++; $display("FAIL t6_r1 got=%h exp=%h", data_b, 32'h6); end
  endtask

  task automatic test_back_to_back();
    int done_at;
    init_req = 1'b1; init_trd = 3'd2; init_data = 32'hBEEF;
    tick();
    init_req = 1'b0;
    done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (init_done) begin done_at = k; break; end
      tick();
    end
    checks++; if (done_at !== 31) begin failures++; $display("FAIL b2b_first_done got=%0d exp=31", done_at); end
    init_req = 1'b1; init_trd = 3'd3; init_data = 32'h55;
    tick();
    init_req = 1'b0;
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", init_busy); end
    done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (init_done) begin done_at = k; break; end
      tick();
    end
    checks++; if (done_at !== 31) begin failures++; $display("FAIL b2b_second_done got=%0d exp=31", done_at); end
    tick();
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", init_busy); end
    set_rd(3'd3, 5'd4, 3'd2, 5'd4);
    tick();
    checks++; if (data_a !== 32'h55) begin failures++; $display("FAIL t3_arg got=%h exp=%h", data_a, 32'h55); end
    checks++; if (data_b !== 32'hBEEF) begin failures++; $display("FAIL t2_arg got=%h exp=%h", data_b, 32'hBEEF); end
    set_rd(3'd3, 5'd2, 3'd2, 5'd3);
    tick();
    checks++; if (data_a !== 32'h0000_CFF0) begin failures++; $display("FAIL t3_sp got=%h exp=%h", data_a, 32'h0000_CFF0); end
    checks++; if (data_b !== 32'h0000_DFF0) begin failures++; $display("FAIL t2_fp got=%h exp=%h", data_b, 32'h0000_DFF0); end
  endtask

  task automatic test_reset_mid();
    int busy_cnt;
    do_write(3'd0, 5'd9, 32'h1);
    init_req = 1'b1; init_trd = 3'd4; init_data = 32'h77;
    tick();
    init_req = 1'b0;
    set_rd(3'd4, 5'd1, 3'd0, 5'd9);
    repeat (5) tick();
    checks++; if (data_a !== 32'h4) begin failures++; $display("FAIL pre_reset_a got=%h exp=%h", data_a, 32'h4); end
    rst_n = 1'b0;
    #1;
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", init_busy); end
    checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL mid_reset_a got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'h0) begin failures++; $display("FAIL mid_reset_b got=%h exp=%h", data_b, 32'h0); end
    tick();
    rst_n = 1'b1;
    set_rd(3'd4, 5'd2, 3'd0, 5'd9);
    tick();
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", init_busy); end
    checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL t4_sp_cleared got=%h exp=%h", data_a, 32'h0); end
    checks++; if (data_b !== 32'h0) begin failures++; $display("FAIL t0_r9_cleared got=%h exp=%h", data_b, 32'h0); end
    init_req = 1'b1; init_trd = 3'd4; init_data = 32'h77;
    tick();
    init_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!init_busy) break;
      busy_cnt++;
      tick();
    end
    checks++; if (busy_cnt !== 32) begin failures++; $display("FAIL post_reset_init_busy got=%0d exp=32", busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_hardwired();
    test_bypass();
    test_init();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mt_regfile.md
# mt_regfile

Parametrised multi-thread register file for the main pipeline. It holds NUM_TRD private banks of NUM_REG x DATA_W registers. It provides two registered read ports, each with its own thread select, and one write port with same-cycle write-through bypass. A multi-cycle init sequencer reloads one thread's bank to its start-of-thread state while every other thread keeps running. It replaces the per-thread register file instances with one block shared by all threads.

## Interface
Parameters:
- NUM_TRD, 8: number of hardware threads; TID_W = $clog2(NUM_TRD).
- NUM_REG, 32: registers per thread, at least 8; REG_W = $clog2(NUM_REG).
- DATA_W, 32: register width.
- INIT_SP_BASE, 32'h0000_FFF0: initial stack pointer of thread 0.
- INIT_SP_STRIDE, 32'h0000_1000: stack spacing; thread t gets INIT_SP_BASE - t*INIT_SP_STRIDE, truncated to DATA_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_trd_a, rd_trd_b  in  TID_W  thread select for read port A / B.
- rd_reg_a, rd_reg_b  in  REG_W  register index for read port A / B.
- wr_en  in  1  write request.
- wr_trd  in  TID_W  write thread.
- wr_reg  in  REG_W  write register index.
- wr_data  in  DATA_W  write data.
- init_req  in  1  request reinitialisation of thread init_trd.
- init_trd  in  TID_W  thread to initialise.
- init_data  in  DATA_W  argument value loaded into r4.
- init_busy  out  1  sequencer active.
- init_done  out  1  one-cycle pulse when the last init write commits.
- data_a, data_b  out  DATA_W  registered read data.

## Operation
- r0 reads 0 and r1 reads the thread id, zero-extended, for every thread. Both are hardwired: writes to index 0 or 1 are dropped and never forwarded.
- Normal write: when wr_en is high and wr_reg > 1, bank[wr_trd][wr_reg] takes wr_data at the clock edge.
- Read port A: data_a takes the first matching case below, in priority order. Port B is identical using rd_trd_b / rd_reg_b.
  - the init write of this cycle, if the sequencer writes the same thread and register;
  - otherwise the normal write of this cycle, if it targets the same thread and register (index > 1) and is not dropped;
  - otherwise the stored value.
- Sequencer states:
  - IDLE: init_req is accepted only in IDLE. On accept, latch init_trd and init_data, set idx = 2, go to LOAD.
  - LOAD: each cycle write bank[trd_q][idx]. The value is the stack pointer for idx 2 and 3, init_data_q for idx 4, and 0 otherwise. idx++. When idx == NUM_REG-1 is written, go to DONE.
  - DONE: pulse init_done for one cycle, return to IDLE.
- init_busy = (state != IDLE), registered. init_req while busy is ignored; there is no queueing and the requester must retry.
- Conflict: a normal write to trd_q while busy is dropped. Normal writes to other threads proceed in the same cycle.
- Reads of trd_q while busy return the partially reloaded bank with init bypass applied. Issuing such reads is a scheduler error, but the returned value is defined as above.

## Timing
- Reset values: all bank entries 0; data_a = data_b = 0; init_busy = 0; init_done = 0; state = IDLE.
- Read latency is 1 cycle: address at edge N gives data valid after edge N+1.
- Init sequence, with init_req sampled at edge N:
  - init_busy = 1 from N until edge N+NUM_REG.
  - LOAD writes occupy edges N+1 .. N+NUM_REG-2 (30 cycles at default).
  - init_done is high for one cycle after edge N+NUM_REG-1 (the DONE state).
  - A new request can be accepted at edge N+NUM_REG.
- An asynchronous reset mid-sequence aborts to IDLE, and every bank returns to 0, including the partially loaded one.

## Structure
- Package mt_regfile_pkg holds:
  - the default NUM_TRD / NUM_REG / DATA_W;
  - the init state enum {IDLE, LOAD, DONE};
  - the register index constants REG_ZERO=0, REG_TID=1, REG_SP=2, REG_FP=3, REG_ARG=4;
  - a function init_sp(tid) computing the stack pointer.
- One sub-module, mt_regfile_init_seq, contains the FSM, idx counter, latched trd_q / init_data_q, and the init write-enable/index/data outputs.
- The top holds the storage array, the write muxing and the read/bypass logic.

## Test plan
- Reset, then read thread 5 r0 and r1 and thread 0 r7 → 0, 5 and 0 one cycle later. A write of 32'hDEAD to thread 5 r1 is dropped, so r1 still reads 5.
- Write 32'h1234_5678 to thread 3 r9 while both ports read thread 3 r9 in the same cycle → both ports return 32'h1234_5678 next cycle. Thread 2 r9 stays 0.
- init_req on thread 6 with init_data = 32'hCAFE, after prior writes to r4 and r20 → init_busy lasts 32 cycles and init_done pulses at cycle 31. Afterwards:
  - r2 = r3 = 32'h0000_9FF0;
  - r4 = 32'hCAFE;
  - r20 = 0.
- During the init of thread 6, write thread 6 r10 = 7 and thread 1 r10 = 9 → the thread 6 write is dropped (r10 = 0 after init) and thread 1 r10 = 9.
- A second init_req during busy is ignored (no extra init_done). A request at the return to IDLE is accepted.
- Assert rst_n low during the LOAD state → init_busy = 0 immediately, all outputs 0, and the FSM is in IDLE after release.
